pipeline_ctrl: RTL and testbench

Sequencing controller for the RV32I in-order pipeline around the decode stage. It tracks in-flight destination registers in a shadow scoreboard and stalls fetch/decode on read-after-write hazards, since there is no forwarding. It flushes wrong-path instructions after a taken branch or jump and freezes the pipeline while data memory is busy. It sits beside `decode` and drives the PC, IF/ID and ID/EX register enables.

---
 rtl/pipeline_ctrl_pkg.sv | 29 ++
 rtl/pipeline_ctrl_scoreboard.sv | 47 ++++
 rtl/pipeline_ctrl.sv | 117 +++++++++++
 tb/tb_pipeline_ctrl.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl shared types.
// FSM states and scoreboard entry layout.
package pipeline_ctrl_pkg;

   localparam int RD_W  = 5;
   localparam int CNT_W = 2;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   typedef struct packed {
      logic            valid;
      logic [RD_W-1:0] rd;
      logic            reg_write;
   } sb_entry_t;

   // Source reads a live, non-x0 destination of this entry.
   function automatic logic src_hit(
      input sb_entry_t       e,
      input logic            use_rs,
      input logic [RD_W-1:0] rs
   );
      return e.valid && e.reg_write && (e.rd != '0) && use_rs && (rs == e.rd);
   endfunction

endpackage

// File: rtl/pipeline_ctrl_scoreboard.sv
// hazard_scoreboard: in-flight destination shift register.
// Flags RAW hazards against every slot except WB.
module hazard_scoreboard
   import pipeline_ctrl_pkg::*;
#(
   parameter int DEPTH = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            advance,
   input  logic            load,
   input  logic [RD_W-1:0] rd,
   input  logic            reg_write,
   input  logic            dec_valid,
   input  logic            use_rs1,
   input  logic [RD_W-1:0] rs1,
   input  logic            use_rs2,
   input  logic [RD_W-1:0] rs2,
   output logic            hazard,
   output logic            slot0_valid
);

   sb_entry_t slots [DEPTH];

   // Shift toward WB; slot 0 takes the issued instruction or a bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
      end else if (advance) begin
         slots[0] <= load ? '{valid: 1'b1, rd: rd, reg_write: reg_write} : '0;
         for (int i = 1; i < DEPTH; i++) slots[i] <= slots[i-1];
      end
   end

   // WB slot is excluded: the register file writes before it reads.
   always_comb begin
      hazard = 1'b0;
      for (int i = 0; i < DEPTH - 1; i++) begin
         if (src_hit(slots[i], use_rs1, rs1) || src_hit(slots[i], use_rs2, rs2))
            hazard = 1'b1;
      end
      hazard = hazard && dec_valid;
   end

   assign slot0_valid = slots[0].valid;

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush/freeze sequencing around decode.
// Drives PC, IF/ID and ID/EX enables; counts stalled cycles.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int DEPTH        = 3,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        dec_valid,
   input  logic [4:0]  dec_rs1,
   input  logic [4:0]  dec_rs2,
   input  logic        dec_use_rs1,
   input  logic        dec_use_rs2,
   input  logic [4:0]  dec_rd,
   input  logic        dec_reg_write,
   input  logic        ex_branch_taken,
   input  logic        mem_busy,
   output logic        pc_write,
   output logic        ifid_write,
   output logic        ifid_flush,
   output logic        idex_bubble,
   output logic [1:0]  state,
   output logic [31:0] stall_cycles
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      stall_q;
   logic             hazard, slot0_valid;
   logic             issue, stall_inc;

   hazard_scoreboard #(.DEPTH(DEPTH)) u_sb (
      .clk         (clk),
      .rst         (rst),
      .advance     (!mem_busy),
      .load        (issue),
      .rd          (dec_rd),
      .reg_write   (dec_reg_write),
      .dec_valid   (dec_valid),
      .use_rs1     (dec_use_rs1),
      .rs1         (dec_rs1),
      .use_rs2     (dec_use_rs2),
      .rs2         (dec_rs2),
      .hazard      (hazard),
      .slot0_valid (slot0_valid)
   );

   // Priority: reset > freeze > flush/branch > hazard > issue.
   always_comb begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      state_d     = state_q;
      cnt_d       = cnt_q;
      issue       = 1'b0;
      stall_inc   = 1'b0;
      if (rst) begin
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else if (mem_busy) begin
         stall_inc = 1'b1;
      end else if (state_q == ST_FLUSH) begin
         pc_write    = 1'b1;
         ifid_write  = 1'b1;
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
         if (cnt_q <= 1) begin
            cnt_d   = '0;
            state_d = ST_RUN;
         end else begin
            cnt_d = cnt_q - 1'b1;
         end
      end else if (ex_branch_taken && slot0_valid) begin
         pc_write    = 1'b1;
         ifid_write  = 1'b1;
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
         if (FLUSH_CYCLES == 1) begin
            state_d = ST_RUN;
            cnt_d   = '0;
         end else begin
            state_d = ST_FLUSH;
            cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
         end
      end else if (hazard) begin
         idex_bubble = 1'b1;
         state_d     = ST_STALL;
         stall_inc   = 1'b1;
      end else begin
         pc_write   = 1'b1;
         ifid_write = 1'b1;
         state_d    = ST_RUN;
         issue      = dec_valid;
      end
   end

   // FSM state, flush counter and saturating stall counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_RUN;
         cnt_q   <= '0;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (stall_inc && (stall_q != 32'hFFFF_FFFF))
            stall_q <= stall_q + 32'd1;
      end
   end

   assign state        = state_q;
   assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed vector table plus reset sequence.
// Expected values are hand-computed per cycle.
module tb_pipeline_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        dec_valid;
   logic [4:0]  dec_rs1, dec_rs2, dec_rd;
   logic        dec_use_rs1, dec_use_rs2, dec_reg_write;
   logic        ex_branch_taken, mem_busy;
   logic        pc_write, ifid_write, ifid_flush, idex_bubble;
   logic [1:0]  state;
   logic [31:0] stall_cycles;

   int n_checks = 0;
   int n_fail   = 0;

   pipeline_ctrl dut (
      .clk             (clk),
      .rst             (rst),
      .dec_valid       (dec_valid),
      .dec_rs1         (dec_rs1),
      .dec_rs2         (dec_rs2),
      .dec_use_rs1     (dec_use_rs1),
      .dec_use_rs2     (dec_use_rs2),
      .dec_rd          (dec_rd),
      .dec_reg_write   (dec_reg_write),
      .ex_branch_taken (ex_branch_taken),
      .mem_busy        (mem_busy),
      .pc_write        (pc_write),
      .ifid_write      (ifid_write),
      .ifid_flush      (ifid_flush),
      .idex_bubble     (idex_bubble),
      .state           (state),
      .stall_cycles    (stall_cycles)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       vld;
      logic [4:0] rs1, rs2;
      logic       u1, u2;
      logic [4:0] rd;
      logic       rw, br, busy;
      logic       pw, iw, fl, bb;
      logic [1:0] st;
      int         sc;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t v(
      input logic vld, input int rs1, input int rs2,
      input logic u1, input logic u2, input int rd,
      input logic rw, input logic br, input logic busy,
      input logic pw, input logic iw, input logic fl,
      input logic bb, input int st, input int sc
   );
      vec_t r;
      r.vld = vld; r.rs1 = 5'(rs1); r.rs2 = 5'(rs2);
      r.u1 = u1; r.u2 = u2; r.rd = 5'(rd);
      r.rw = rw; r.br = br; r.busy = busy;
      r.pw = pw; r.iw = iw; r.fl = fl; r.bb = bb;
      r.st = 2'(st); r.sc = sc;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t x);
      dec_valid       = x.vld;
      dec_rs1         = x.rs1;
      dec_rs2         = x.rs2;
      dec_use_rs1     = x.u1;
      dec_use_rs2     = x.u2;
      dec_rd          = x.rd;
      dec_reg_write   = x.rw;
      ex_branch_taken = x.br;
      mem_busy        = x.busy;
   endtask

   task automatic check_outs(input string tag, input vec_t x);
      chk({tag, ".pc_write"},     32'(pc_write),    32'(x.pw));
      chk({tag, ".ifid_write"},   32'(ifid_write),  32'(x.iw));
      chk({tag, ".ifid_flush"},   32'(ifid_flush),  32'(x.fl));
      chk({tag, ".idex_bubble"},  32'(idex_bubble), 32'(x.bb));
      chk({tag, ".state"},        32'(state),       32'(x.st));
      chk({tag, ".stall_cycles"}, stall_cycles,     32'(x.sc));
   endtask

   initial begin
      vec_t idle, x;
      idle = v(0,0,0,0,0,0,0,0,0, 0,0,1,1,0,0);
      rst = 1'b1;
      drive(idle);
      repeat (2) @(posedge clk);
      #1;
      check_outs("reset", idle);
      rst = 1'b0;

      // add x5,x1,x2 ; sub x6,x5,x3 -> two stall cycles
      vecs.push_back(v(1,1,2,1,1,5,1,0,0, 1,1,0,0,0,0));
      vecs.push_back(v(1,5,3,1,1,6,1,0,0, 0,0,0,1,0,0));
      vecs.push_back(v(1,5,3,1,1,6,1,0,0, 0,0,0,1,1,1));
      vecs.push_back(v(1,5,3,1,1,6,1,0,0, 1,1,0,0,1,2));
      // x0 writer then x0 reader; unused rs2 matches x6
      vecs.push_back(v(1,0,0,0,0,0,1,0,0, 1,1,0,0,0,2));
      vecs.push_back(v(1,0,6,1,0,10,0,0,0, 1,1,0,0,0,2));
      // x6 now in WB slot only
      vecs.push_back(v(1,6,0,1,0,7,1,0,0, 1,1,0,0,0,2));
      // branch with simultaneous hazard on x7, then one FLUSH cycle
      vecs.push_back(v(1,7,0,1,0,11,1,1,0, 1,1,1,1,0,2));
      vecs.push_back(v(1,7,0,1,0,11,1,1,0, 1,1,1,1,2,2));
      vecs.push_back(v(1,7,0,1,0,8,1,0,0, 1,1,0,0,0,2));
      // stall on x8 interrupted by 4 busy cycles
      vecs.push_back(v(1,8,0,1,0,12,1,0,0, 0,0,0,1,0,2));
      for (int i = 0; i < 4; i++)
         vecs.push_back(v(1,8,0,1,0,12,1,0,1, 0,0,0,0,1,3+i));
      vecs.push_back(v(1,8,0,1,0,12,1,0,0, 0,0,0,1,1,7));
      vecs.push_back(v(1,8,0,1,0,9,1,0,0, 1,1,0,0,1,8));
      // branch deferred by mem_busy
      vecs.push_back(v(0,0,0,0,0,0,0,1,1, 0,0,0,0,0,8));
      vecs.push_back(v(0,0,0,0,0,0,0,1,0, 1,1,1,1,0,9));
      vecs.push_back(v(0,0,0,0,0,0,0,0,0, 1,1,1,1,2,9));
      vecs.push_back(v(1,9,0,1,0,13,1,0,0, 1,1,0,0,0,9));

      foreach (vecs[i]) begin
         drive(vecs[i]);
         @(negedge clk);
         check_outs($sformatf("vec%0d", i), vecs[i]);
         @(posedge clk);
         #1;
      end

      // branch on x13 then reset in the middle of FLUSH
      x = v(0,0,0,0,0,0,0,1,0, 1,1,1,1,0,9);
      drive(x);
      @(negedge clk);
      check_outs("rbr", x);
      @(posedge clk);
      #1;
      chk("rflush.state", 32'(state), 32'd2);
      ex_branch_taken = 1'b0;
      #1;
      rst = 1'b1;
      #1;
      check_outs("rst_mid", v(0,0,0,0,0,0,0,0,0, 0,0,1,1,0,0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      // reader of x13: scoreboard must be empty after reset
      x = v(1,13,0,1,0,14,1,0,0, 1,1,0,0,0,0);
      drive(x);
      @(negedge clk);
      check_outs("post_rst", x);
      @(posedge clk);
      #1;

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
